// File: rtl/sm_bus_master_pkg.sv
// Shared constants for the schoolMIPS bus master: state encodings and beat address step.
package sm_bus_master_pkg;

  typedef enum logic [1:0] {
    SM_BUSM_IDLE = 2'd0,
    SM_BUSM_BEAT = 2'd1,
    SM_BUSM_RESP = 2'd2
  } busmState_t;

  localparam int SM_BUS_ADDR_STEP = 4;

endpackage

// File: rtl/sm_bus_master_fsm.sv
// Sequencing core of the bus master: state register, remaining-beat counter and next-state logic.
module sm_bus_master_fsm
  import sm_bus_master_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmdValid,
  input  logic [LEN_W-1:0] cmdLen,
  input  logic             writeReg,
  input  logic             rspReady,
  output busmState_t       state,
  output logic             accept,
  output logic             lastBeat,
  output logic             incAddr
);

  busmState_t       stateNext;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] remNext;

  // rem counts beats still to issue after the current one; it only moves when the address does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SM_BUSM_IDLE;
      rem   <= '0;
    end else begin
      state <= stateNext;
      rem   <= remNext;
    end
  end

  assign lastBeat = (rem == '0);

  always_comb begin
    stateNext = state;
    remNext   = rem;
    accept    = 1'b0;
    incAddr   = 1'b0;
    case (state)
      SM_BUSM_IDLE: begin
        if (cmdValid && !rst) begin
          accept    = 1'b1;
          remNext   = cmdLen;
          stateNext = SM_BUSM_BEAT;
        end
      end
      SM_BUSM_BEAT: begin
        if (!writeReg || lastBeat) begin
          stateNext = SM_BUSM_RESP;
        end else begin
          incAddr = 1'b1;
          remNext = rem - 1'b1;
        end
      end
      SM_BUSM_RESP: begin
        if (rspReady) begin
          if (lastBeat) begin
            stateNext = SM_BUSM_IDLE;
          end else begin
            incAddr   = 1'b1;
            remNext   = rem - 1'b1;
            stateNext = SM_BUSM_BEAT;
          end
        end
      end
      default: stateNext = SM_BUSM_IDLE;
    endcase
  end

endmodule

// File: rtl/sm_bus_master.sv
// schoolMIPS peripheral bus initiator: turns valid/ready read/write burst commands into
// single-cycle bus strobes and returns read data / write acks on a valid/ready response port.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1; valid,
// once raised, holds its payload stable until that edge.
module sm_bus_master
  import sm_bus_master_pkg::*;
#(
  parameter int LEN_W     = 4,
  parameter int ADDR_STEP = SM_BUS_ADDR_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic             cmdWrite,
  input  logic [31:0]      cmdAddr,
  input  logic [31:0]      cmdWData,
  input  logic [LEN_W-1:0] cmdLen,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [31:0]      rspRData,
  output logic             rspLast,
  output logic             busy,
  output logic             bSel,
  output logic [31:0]      bAddr,
  output logic             bWrite,
  output logic [31:0]      bWData,
  input  logic [31:0]      bRData
);

  busmState_t  state;
  logic        accept;
  logic        lastBeat;
  logic        incAddr;
  logic        writeReg;
  logic [31:0] curAddr;
  logic [31:0] wdataReg;

  sm_bus_master_fsm #(.LEN_W(LEN_W)) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .cmdValid (cmdValid),
    .cmdLen   (cmdLen),
    .writeReg (writeReg),
    .rspReady (rspReady),
    .state    (state),
    .accept   (accept),
    .lastBeat (lastBeat),
    .incAddr  (incAddr)
  );

  // curAddr only advances right before the next beat, so bAddr keeps the last beat address when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      writeReg <= 1'b0;
      curAddr  <= '0;
      wdataReg <= '0;
      rspRData <= '0;
      rspLast  <= 1'b0;
    end else begin
      if (accept) begin
        writeReg <= cmdWrite;
        curAddr  <= cmdAddr;
        wdataReg <= cmdWData;
      end else if (incAddr) begin
        curAddr <= curAddr + 32'(ADDR_STEP);
      end
      if (state == SM_BUSM_BEAT) begin
        if (!writeReg) begin
          rspRData <= bRData;
          rspLast  <= lastBeat;
        end else if (lastBeat) begin
          rspRData <= '0;
          rspLast  <= 1'b1;
        end
      end
    end
  end

  assign cmdReady = (state == SM_BUSM_IDLE) && !rst;
  assign busy     = (state != SM_BUSM_IDLE);
  assign rspValid = (state == SM_BUSM_RESP);
  assign bSel     = (state == SM_BUSM_BEAT);
  assign bAddr    = curAddr;
  assign bWData   = wdataReg;
  assign bWrite   = bSel && writeReg;

endmodule
